block_emitter: RTL
==================

BLOCK_EMITTER -- requirements
Module: block_emitter

Interface
REQ-001 Parameter DEPTH_W, default 8: width of the nesting-depth counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present this cycle.
REQ-005 cmd_is_end  input  1  0 = emit "begin", 1 = emit "end".
REQ-006 cmd_upper  input  1  1 = emit keyword letters in uppercase.
REQ-007 cmd_ready  output  1  emitter can accept a command this cycle.
REQ-008 out  output  8  ASCII character stream, one character per cycle.
REQ-009 out_valid  output  1  out carries a stream character this cycle.
REQ-010 depth  output  DEPTH_W  current count of open "begin" words not yet closed.
REQ-011 balanced  output  1  high when depth == 0.
REQ-012 err  output  1  sticky flag for rejected commands.

Function
REQ-013 A command shall be accepted on a rising edge where cmd_valid && cmd_ready.
REQ-014 cmd_ready shall be high in IDLE and during the cycle in which the trailing space is on out; it shall be low otherwise.
REQ-015 The state machine shall have the states IDLE, WORD (letters in progress) and SPACE (trailing 0x20 on out).
REQ-016 Accepted BEGIN: out/out_valid shall present 'b','e','g','i','n',' ' on 6 consecutive cycles, starting in the cycle after acceptance.
REQ-017 Accepted END: out/out_valid shall present 'e','n','d',' ' on 4 consecutive cycles, starting in the cycle after acceptance.
REQ-018 cmd_upper shall be latched at acceptance. When it is set, letters shall be 0x20 lower in value (A–Z); the space shall be unaffected.
REQ-019 out shall be a registered output. In IDLE, out shall be 0x20 and out_valid shall be 0.
REQ-020 A command accepted in the SPACE cycle shall start its first letter on the very next cycle, with no gap.
REQ-021 depth shall increment in the acceptance cycle of a legal BEGIN and decrement in the acceptance cycle of a legal END.
REQ-022 An END with depth == 0 shall be consumed without emission: err shall be set, depth shall be unchanged, and the emitter shall return to or stay in IDLE.
REQ-023 A BEGIN with depth == all-ones shall be consumed without emission: err shall be set and depth shall not wrap.
REQ-024 A rejected command accepted in the SPACE cycle shall be followed by IDLE (out_valid = 0) on the next cycle.
REQ-025 err shall be cleared only by reset.
REQ-026 cmd_valid while cmd_ready is low shall be ignored, with no side effects.
REQ-027 Any emitted stream shall be accepted by a character-per-clock begin/end block checker as balanced iff balanced == 1 after the last space.

Reset
REQ-028 On reset low, the following shall take effect immediately and asynchronously: state = IDLE, out = 0x20, out_valid = 0, depth = 0, err = 0, cmd_ready = 1 once reset is released.
REQ-029 Reset asserted mid-word shall abandon the word; the first cycle after release shall be IDLE.

Structure
REQ-030 Package block_pkg shall hold:
- the state enum (IDLE, WORD, SPACE);
- ASCII constants for space and the case offset 0x20;
- keyword lengths (BEGIN_LEN = 5, END_LEN = 3).
REQ-031 One sub-module, keyword_rom, shall map (is_end, letter index) to a lowercase letter combinationally.
REQ-032 Letter index shall be a 3-bit counter inside block_emitter, cleared at every acceptance.

Verification
REQ-033 Reset; BEGIN (lower) at cycle 2 -> out = 62 65 67 69 6E 20 on cycles 3–8; depth = 1 from cycle 3; balanced = 0.
REQ-034 BEGIN presented in the space cycle, then END, upper -> B,E,G,I,N,' ' immediately followed by E,N,D,' ' with no idle cycle; final depth = 0, balanced = 1.
REQ-035 END from reset -> no out_valid; err = 1; depth = 0; next BEGIN still emits normally.
REQ-036 DEPTH_W = 2; four BEGINs -> fourth rejected, err = 1, depth stays 3; out_valid count = 18.
REQ-037 Reset low during the 'g' of BEGIN -> out = 0x20 and out_valid = 0 immediately; depth = 0.
REQ-038 Random legal command sequence fed to the block checker model -> checker result equals balanced after every space.

Source files
------------

// File: rtl/block_pkg.sv
// block_pkg: shared FSM states, ASCII constants and keyword lengths for block_emitter.
package block_pkg;
   typedef enum logic [1:0] {IDLE, WORD, SPACE} state_e;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] CASE_OFFSET = 8'h20;
   localparam logic [2:0] BEGIN_LEN = 3'd5;
   localparam logic [2:0] END_LEN = 3'd3;
   function automatic logic [2:0] kw_len(input logic is_end);
      return is_end ? END_LEN : BEGIN_LEN;
   endfunction
endpackage

// File: rtl/keyword_rom.sv
// keyword_rom: lowercase letter of "begin"/"end" at a given index; out-of-range yields a space.
module keyword_rom
   import block_pkg::*;
(
   input  logic       is_end,
   input  logic [2:0] idx,
   output logic [7:0] ch
);
   always_comb begin
      ch = ASCII_SPACE;
      case ({is_end, idx})
         4'b0_000: ch = "b";
         4'b0_001: ch = "e";
         4'b0_010: ch = "g";
         4'b0_011: ch = "i";
         4'b0_100: ch = "n";
         4'b1_000: ch = "e";
         4'b1_001: ch = "n";
         4'b1_010: ch = "d";
         default:  ch = ASCII_SPACE;
      endcase
   end
endmodule

// File: rtl/block_emitter.sv
// block_emitter: streams "begin "/"end " one character per clock while tracking nesting depth.
module block_emitter
   import block_pkg::*;
#(
   parameter int DEPTH_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic               cmd_is_end,
   input  logic               cmd_upper,
   output logic               cmd_ready,
   output logic [7:0]         out,
   output logic               out_valid,
   output logic [DEPTH_W-1:0] depth,
   output logic               balanced,
   output logic               err
);
   state_e             state_q, state_d;
   logic [2:0]         idx_q, idx_d, rom_idx;
   logic               is_end_q, is_end_d, upper_q, upper_d;
   logic [7:0]         out_q, out_d, rom_ch, letter;
   logic               out_valid_q, out_valid_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               err_q, err_d;
   logic               accept, legal, rom_end, word_done;

   assign cmd_ready = state_q != WORD;
   assign accept    = cmd_valid && cmd_ready;
   assign legal     = cmd_is_end ? (depth_q != '0) : (depth_q != '1);
   // The ROM looks one character ahead so out can stay a plain register.
   assign rom_end   = accept ? cmd_is_end : is_end_q;
   assign rom_idx   = accept ? 3'd0 : idx_q + 3'd1;
   assign letter    = (accept ? cmd_upper : upper_q) ? rom_ch - CASE_OFFSET : rom_ch;
   assign word_done = (state_q == WORD) && (idx_q + 3'd1 == kw_len(is_end_q));

   keyword_rom u_rom (
      .is_end(rom_end),
      .idx   (rom_idx),
      .ch    (rom_ch)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      is_end_d = is_end_q;
      upper_d  = upper_q;
      depth_d  = depth_q;
      err_d    = err_q;
      if (accept) begin
         idx_d    = 3'd0;
         is_end_d = cmd_is_end;
         upper_d  = cmd_upper;
         state_d  = legal ? WORD : IDLE;
         err_d    = err_q || !legal;
         depth_d  = !legal ? depth_q : cmd_is_end ? depth_q - 1'b1 : depth_q + 1'b1;
      end else if (state_q == WORD) begin
         state_d = word_done ? SPACE : WORD;
         idx_d   = word_done ? idx_q : idx_q + 3'd1;
      end else begin
         state_d = IDLE;
      end
      out_d       = (state_d == WORD) ? letter : ASCII_SPACE;
      out_valid_d = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         is_end_q    <= 1'b0;
         upper_q     <= 1'b0;
         out_q       <= ASCII_SPACE;
         out_valid_q <= 1'b0;
         depth_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         is_end_q    <= is_end_d;
         upper_q     <= upper_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         depth_q     <= depth_d;
         err_q       <= err_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign depth     = depth_q;
   assign balanced  = depth_q == '0;
   assign err       = err_q;
endmodule
